btn_debounce_bank: RTL and testbench
====================================

// Module: btn_debounce_bank
// PURPOSE
//   Input conditioning stage for the four user buttons on ui_in[3:0], placed directly upstream of the
//   segment-changing logic. Each button gets a 2-FF synchronizer and a stability counter.
//   Per button the block outputs a clean level, a one-cycle press pulse and a one-cycle release pulse.
//   Bounces shorter than DEBOUNCE_CYCLES clocks never reach the display logic.
// PARAMETERS
//   N_BTN            4      number of independent button channels
//   DEBOUNCE_CYCLES  50000  consecutive stable cycles required to accept a new level (5 ms @ 10 MHz); must be >= 2
//   CNT_W            16     counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES (elaboration-time check)
// PORTS
//   clk          in   1      system clock, 10 MHz nominal, all logic on rising edge
//   rst_n        in   1      asynchronous active-low reset
//   ena          in   1      design enable; low = freeze filtering (see BEHAVIOUR)
//   btn_raw      in   N_BTN  raw asynchronous button inputs, active high
//   btn_level    out  N_BTN  debounced button level
//   btn_press    out  N_BTN  one-cycle pulse on accepted 0->1 transition
//   btn_release  out  N_BTN  one-cycle pulse on accepted 1->0 transition
// BEHAVIOUR
//   Reset (async assert, sync-safe deassert path):
//     - sync FFs, counters, btn_level, btn_press and btn_release all go to 0 immediately.
//   Synchronizer: btn_raw -> s1 -> s2 (2 flops). s2 is the filtered input.
//   Per-channel counter, evaluated each rising edge with ena=1:
//     - s2 == btn_level: cnt <= 0.
//     - s2 != btn_level and cnt <  D-1: cnt <= cnt+1.
//     - s2 != btn_level and cnt == D-1: btn_level <= s2, cnt <= 0, and the matching pulse is driven high.
//       The pulse is btn_press if s2 = 1, btn_release if s2 = 0.
//   Pulses: registered, high for exactly 1 cycle, in the same cycle btn_level changes; 0 otherwise.
//   Latency: a raw change held steady updates btn_level on the (D+2)th rising edge.
//     - Edge numbering: the first edge that samples the new raw value is edge 1.
//     - Example: D=4 gives update on edge 6.
//   Filtering: any return of s2 to btn_level before the count completes clears cnt.
//     - The next mismatch therefore restarts counting from 0.
//     - Mismatch runs shorter than D cycles produce no level change and no pulse.
//   ena=0:
//     - Sync FFs keep sampling.
//     - Counters are held at 0.
//     - btn_level holds its value.
//     - Pulses are 0.
//   After ena returns to 1, filtering restarts from a zero count.
//   Channels are fully independent. Simultaneous transitions on several buttons produce
//   simultaneous pulses in the same cycle.
//   Reset mid-count: all state goes to 0. No pulse is emitted on or after reset release unless a
//   new full stable period elapses.
//   Counter never wraps: its maximum is D-1 by construction.
// STRUCTURE
//   Shared package seg_fun_pkg:
//     - N_BTN_DEFAULT = 4
//     - DEBOUNCE_CYCLES_DEFAULT = 50000
//     - CLK_HZ = 10_000_000
//     - button index constants BTN_0..BTN_3
//   Sub-module debounce_channel (one bit: synchronizer, counter, level register and pulse registers).
//     - Instantiated N_BTN times in a generate loop.
//   Top-level wrapper only concatenates the channel outputs.
// TESTING (bench overrides DEBOUNCE_CYCLES=4, clk period 100 ns)
//   1. Reset:
//      rst_n=0 for 20 ns, btn_raw=4'h0 -> all outputs 0 during and after reset.
//      Assert rst_n mid-cycle -> outputs clear without waiting for a clock edge.
//   2. Clean press:
//      btn_raw[0] 0->1 and held -> btn_level[0]=1 on edge 6; btn_press[0] high for exactly that one cycle.
//      Hold for 20 more cycles -> no further pulses.
//   3. Bounce:
//      btn_raw[1] toggled every 200 ns, 8 times, then 0 -> btn_level[1] stays 0 and no pulses.
//      Repeat ending with a steady 1 -> a single btn_press[1] on edge 6 after the last toggle.
//   4. Release:
//      from btn_level[2]=1, drop btn_raw[2] to 0 -> btn_release[2] for 1 cycle on edge 6 and btn_level[2]=0.
//      btn_press[2] stays 0 throughout.
//   5. Simultaneous:
//      btn_raw 4'h0 -> 4'hF in one step -> btn_press=4'hF in a single cycle and btn_level=4'hF.
//   6. Reset and ena mid-count:
//      rst_n low after 2 stable cycles -> no pulse, all outputs 0.
//      ena=0 while btn_raw[3]=1 -> btn_level[3] holds.
//      ena back to 1 -> btn_press[3] 6 edges later.

Source files
------------

// File: rtl/seg_fun_pkg.sv
// Shared constants for the seg_fun button input path: channel count,
// debounce defaults and button index names.
package seg_fun_pkg;

    localparam int N_BTN_DEFAULT           = 4;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;
    localparam int CNT_W_DEFAULT           = 16;
    localparam int CLK_HZ                  = 10_000_000;

    localparam int unsigned BTN_0 = 0;
    localparam int unsigned BTN_1 = 1;
    localparam int unsigned BTN_2 = 2;
    localparam int unsigned BTN_3 = 3;

endpackage

// File: rtl/debounce_channel.sv
// One debounced button: 2-FF synchronizer, stability counter, level register
// and registered one-cycle press/release pulses.
module debounce_channel
    import seg_fun_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
        $error("debounce_channel: DEBOUNCE_CYCLES must be >= 2");
    end
    if ((2 ** CNT_W) <= DEBOUNCE_CYCLES) begin : g_bad_width
        $error("debounce_channel: CNT_W too narrow for DEBOUNCE_CYCLES");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;
    logic             r_release;

    logic w_mismatch;
    logic w_done;

    assign w_mismatch = r_s2 ^ r_level;
    assign w_done     = w_mismatch && (r_cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_s1      <= btn_raw;
            r_s2      <= r_s1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            // The synchronizer keeps running while disabled so the input is fresh on re-enable.
            if (!ena || !w_mismatch) begin
                r_cnt <= '0;
            end else if (w_done) begin
                r_level   <= r_s2;
                r_cnt     <= '0;
                r_press   <= r_s2;
                r_release <= ~r_s2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign btn_level   = r_level;
    assign btn_press   = r_press;
    assign btn_release = r_release;

endmodule

// File: rtl/btn_debounce_bank.sv
// Bank of independent button debouncers; the wrapper only replicates the
// channel and concatenates its outputs.
module btn_debounce_bank
    import seg_fun_pkg::*;
#(
    parameter int N_BTN           = N_BTN_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .ena         (ena),
            .btn_raw     (btn_raw[g]),
            .btn_level   (btn_level[g]),
            .btn_press   (btn_press[g]),
            .btn_release (btn_release[g])
        );
    end

endmodule

// File: tb/tb_btn_debounce_bank.sv
// Directed bench for btn_debounce_bank with DEBOUNCE_CYCLES=4 and a 100 ns clock.
module tb_btn_debounce_bank;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [3:0] btn_raw;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;

    int tests = 0;
    int fails = 0;

    btn_debounce_bank #(
        .N_BTN           (4),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    always #50 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change on falling edges; one tick = one rising edge, then sample on the next falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_all(input string tag, input logic [3:0] lvl, input logic [3:0] prs,
                           input logic [3:0] rel);
        chk({tag, " level"},   btn_level,   lvl);
        chk({tag, " press"},   btn_press,   prs);
        chk({tag, " release"}, btn_release, rel);
    endtask

    initial begin
        // 1. Reset
        rst_n   = 1'b0;
        ena     = 1'b1;
        btn_raw = 4'h0;
        #20;
        chk_all("rst_during", 4'h0, 4'h0, 4'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk_all("rst_after", 4'h0, 4'h0, 4'h0);

        // 2. Clean press on button 0
        btn_raw = 4'b0001;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk_all("press0_wait", 4'h0, 4'h0, 4'h0);
        end
        tick();
        chk_all("press0_edge6", 4'b0001, 4'b0001, 4'h0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_all("press0_hold", 4'b0001, 4'h0, 4'h0);
        end

        // 3. Bounce on button 1: 8 toggles at 200 ns, ending low
        for (int t = 0; t < 8; t++) begin
            btn_raw[1] = ~btn_raw[1];
            for (int i = 0; i < 2; i++) begin
                tick();
                chk_all("bounce_lo", 4'b0001, 4'h0, 4'h0);
            end
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_all("bounce_lo_settle", 4'b0001, 4'h0, 4'h0);
        end
        // 7 toggles so the final one leaves the input high
        for (int t = 0; t < 7; t++) begin
            btn_raw[1] = ~btn_raw[1];
            if (t < 6) begin
                for (int i = 0; i < 2; i++) begin
                    tick();
                    chk_all("bounce_hi", 4'b0001, 4'h0, 4'h0);
                end
            end
        end
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk_all("bounce_hi_wait", 4'b0001, 4'h0, 4'h0);
        end
        tick();
        chk_all("bounce_hi_edge6", 4'b0011, 4'b0010, 4'h0);
        tick();
        chk_all("bounce_hi_after", 4'b0011, 4'h0, 4'h0);

        // 4. Release on button 2
        btn_raw = 4'b0111;
        for (int i = 1; i <= 6; i++) tick();
        chk_all("rel2_setup", 4'b0111, 4'b0100, 4'h0);
        tick();
        btn_raw = 4'b0011;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk_all("rel2_wait", 4'b0111, 4'h0, 4'h0);
        end
        tick();
        chk_all("rel2_edge6", 4'b0011, 4'h0, 4'b0100);
        tick();
        chk_all("rel2_after", 4'b0011, 4'h0, 4'h0);

        // 5. Simultaneous transitions
        btn_raw = 4'h0;
        for (int i = 1; i <= 6; i++) tick();
        chk_all("all_release", 4'h0, 4'h0, 4'b0011);
        tick();
        btn_raw = 4'hF;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk_all("all_press_wait", 4'h0, 4'h0, 4'h0);
        end
        tick();
        chk_all("all_press_edge6", 4'hF, 4'hF, 4'h0);
        tick();
        chk_all("all_press_after", 4'hF, 4'h0, 4'h0);

        // 6a. Reset mid-count, asserted between clock edges
        btn_raw = 4'h0;
        for (int i = 1; i <= 4; i++) tick();
        chk_all("midcount", 4'hF, 4'h0, 4'h0);
        #10 rst_n = 1'b0;
        #5;
        chk_all("async_clear", 4'h0, 4'h0, 4'h0);
        tick();
        chk_all("rst_hold", 4'h0, 4'h0, 4'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_all("post_rst", 4'h0, 4'h0, 4'h0);
        end

        // 6b. ena=0 freezes filtering
        ena     = 1'b0;
        btn_raw = 4'b1000;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_all("ena_off_hold", 4'h0, 4'h0, 4'h0);
        end
        btn_raw = 4'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("ena_off_lo", 4'h0, 4'h0, 4'h0);
        end
        ena     = 1'b1;
        btn_raw = 4'b1000;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk_all("ena_on_wait", 4'h0, 4'h0, 4'h0);
        end
        tick();
        chk_all("ena_on_edge6", 4'b1000, 4'b1000, 4'h0);
        tick();
        chk_all("ena_on_after", 4'b1000, 4'h0, 4'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
